im_loader: RTL and testbench
============================

IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning byte-address width of the instruction memory write port.
REQ-002 SHALL have parameter CNT_W, default 9, meaning word-count width, with a maximum load of 256 words.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load; sampled in IDLE only.
REQ-006 SHALL have port base_addr  input  ADDR_W  first byte address; bits [1:0] are ignored and forced to 0.
REQ-007 SHALL have port word_count  input  CNT_W  number of 32-bit words to load, 0..256.
REQ-008 SHALL have port in_valid  input  1  upstream word valid.
REQ-009 SHALL have port in_word  input  32  upstream instruction word.
REQ-010 SHALL have port in_ready  output  1  loader accepts in_word this cycle.
REQ-011 SHALL have port mem_we  output  1  byte write strobe to instruction memory.
REQ-012 SHALL have port mem_addr  output  ADDR_W  byte address being written.
REQ-013 SHALL have port mem_wdata  output  8  byte being written.
REQ-014 SHALL have port busy  output  1  load in progress; holds the CPU PC.
REQ-015 SHALL have port done  output  1  one-cycle pulse when a load completes.
REQ-016 SHALL have port wrap_err  output  1  sticky flag: the address wrapped past 2^ADDR_W-1 during the current load.

Function
REQ-017 SHALL implement the FSM states IDLE, ACCEPT, WRITE, and DONE.
REQ-018 SHALL, in IDLE on start=1, latch {base_addr[ADDR_W-1:2],2'b00} into the address counter, latch word_count into the remaining counter, clear wrap_err, and go to ACCEPT; if word_count=0, go to DONE instead.
REQ-019 SHALL assert in_ready only in ACCEPT; on in_valid&in_ready, capture in_word, clear the byte index to 0, and go to WRITE.
REQ-020 SHALL, in WRITE, assert mem_we for exactly 4 consecutive cycles in big-endian order: index 0 writes in_word[31:24] at addr, index 1 writes [23:16] at addr+1, index 2 writes [15:8] at addr+2, and index 3 writes [7:0] at addr+3.
REQ-021 SHALL increment the address by 1 after each byte modulo 2^ADDR_W; when the increment is from 2^ADDR_W-1 to 0, wrap_err SHALL be set.
REQ-022 SHALL, after byte index 3, decrement the remaining counter; if the result is 0, go to DONE, else go to ACCEPT.
REQ-023 SHALL have a latency of 1 cycle from word acceptance to the first mem_we, and a throughput of 1 word per 5 cycles while in_valid is held high.
REQ-024 SHALL, in DONE, assert done for 1 cycle and return to IDLE.
REQ-025 SHALL hold busy=1 in ACCEPT, WRITE, and DONE, and busy=0 in IDLE.
REQ-026 SHALL ignore start while not in IDLE.
REQ-027 SHALL ignore in_valid outside ACCEPT, so no word is consumed.
REQ-028 SHALL drive mem_addr and mem_wdata to 0 whenever mem_we=0.
REQ-029 SHALL treat word_count>256 as 256.

Reset
REQ-030 SHALL, on rst=1 at a rising clk edge, enter IDLE and drive in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, and wrap_err=0, and clear all counters.
REQ-031 SHALL, on reset mid-load, abandon the partial word with no further mem_we after the reset edge, and SHALL NOT pulse done.
REQ-032 SHALL give rst priority over start when both are asserted in the same cycle.

Structure
REQ-033 SHALL place the FSM state encoding and the constants BYTES_PER_WORD=4 and IM_BYTES=1024 in a shared package, also used by the instruction memory.
REQ-034 SHALL be a single module with no sub-modules; the byte serializer is inline.

Verification
REQ-035 SHALL cover this scenario: start, base=0x000, count=1, word 0x8C010004 -> writes 0x8C@0, 0x01@1, 0x00@2, 0x04@3 on cycles N+1..N+4, with done at N+5.
REQ-036 SHALL cover this scenario: start, base=0x102 (unaligned), count=2, words 0x11223344 and 0xAABBCCDD -> bytes at 0x100..0x107 in order 11 22 33 44 AA BB CC DD, with wrap_err=0.
REQ-037 SHALL cover this scenario: start, base=0x3FC, count=2 -> second word written at 0x000..0x003, wrap_err=1 after the 0x3FF write and held until the next start.
REQ-038 SHALL cover this scenario: start, count=0 -> done pulses one cycle after start, with no mem_we and no in_ready.
REQ-039 SHALL cover this scenario: rst asserted during byte index 2 of the first word -> mem_we=0 from the next cycle, busy=0, done never pulses.
REQ-040 SHALL cover this scenario: in_valid toggled randomly during a count=3 load, with start pulsed while busy -> exactly 12 byte writes, start ignored, and done pulsed once.

Source files
------------

// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction memory.
package im_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } im_state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned IM_BYTES       = 1024;
  localparam int unsigned MAX_WORDS      = 256;

endpackage

// File: rtl/im_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory port,
// big-endian, one word per five cycles, holding the CPU via busy while loading.
module im_loader #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  input  logic [31:0]       in_word,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              wrap_err
);
  import im_loader_pkg::*;

  localparam logic [CNT_W-1:0]  MAX_CNT    = CNT_W'(MAX_WORDS);
  localparam logic [1:0]        LAST_IDX   = 2'(BYTES_PER_WORD - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  im_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [CNT_W-1:0]  rem_q,   rem_d;
  logic [1:0]        idx_q,   idx_d;
  logic [31:0]       word_q,  word_d;
  logic              wrap_q,  wrap_d;
  logic [7:0]        byte_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    word_d  = word_q;
    wrap_d  = wrap_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = base_addr & ALIGN_MASK;
          rem_d   = (word_count > MAX_CNT) ? MAX_CNT : word_count;
          wrap_d  = 1'b0;
          state_d = (word_count == '0) ? ST_DONE : ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (in_valid) begin
          word_d  = in_word;
          idx_d   = '0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // The final byte at the top address also wraps, so the flag is set
        // even when the load ends exactly on the last byte of memory.
        addr_d = addr_q + ADDR_W'(1);
        if (&addr_q) wrap_d = 1'b1;
        idx_d = idx_q + 2'd1;
        if (idx_q == LAST_IDX) begin
          rem_d   = rem_q - CNT_W'(1);
          state_d = (rem_q == CNT_W'(1)) ? ST_DONE : ST_ACCEPT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    case (idx_q)
      2'd0:    byte_sel = word_q[31:24];
      2'd1:    byte_sel = word_q[23:16];
      2'd2:    byte_sel = word_q[15:8];
      default: byte_sel = word_q[7:0];
    endcase
    in_ready  = (state_q == ST_ACCEPT);
    mem_we    = (state_q == ST_WRITE);
    mem_addr  = mem_we ? addr_q : '0;
    mem_wdata = mem_we ? byte_sel : '0;
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    wrap_err  = wrap_q;
  end

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: a negedge monitor pops expected byte writes
// from a scoreboard queue; scenario tasks check timing and status outputs inline.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [9:0]  base_addr;
  logic [8:0]  word_count;
  logic [31:0] in_word;
  logic        in_ready, mem_we, busy, done, wrap_err;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;
  int done_cnt = 0;
  logic [17:0] sb_q[$];

  im_loader #(.ADDR_W(10), .CNT_W(9)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_word(in_word),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .wrap_err(wrap_err)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (mem_we === 1'b1) begin
      wr_cnt++;
      n_tests++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_unexpected_write: got addr=%h data=%h, required no write", mem_addr, mem_wdata);
        n_fail++;
      end else begin
        logic [17:0] exp_e;
        exp_e = sb_q.pop_front();
        if ({mem_addr, mem_wdata} !== exp_e) begin
          $display("FAIL sb_write: got addr=%h data=%h, required addr=%h data=%h",
                   mem_addr, mem_wdata, exp_e[17:8], exp_e[7:0]);
          n_fail++;
        end
      end
    end else if (mem_we === 1'b0) begin
      n_tests++;
      if ({mem_addr, mem_wdata} !== 18'h0) begin
        $display("FAIL idle_bus_zero: got addr=%h data=%h, required 0", mem_addr, mem_wdata);
        n_fail++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [9:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [9:0] ai;
      logic [7:0] bi;
      ai = a + 10'(i);
      bi = w[31 - 8*i -: 8];
      sb_q.push_back({ai, bi});
    end
  endtask

  task automatic pulse_start(input logic [9:0] b, input logic [8:0] c);
    base_addr = b; word_count = c; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    in_word = w; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin tick(); n++; end
    n_tests++;
    if (in_ready !== 1'b1) begin
      $display("FAIL send_word_timeout: in_ready=%b, required 1", in_ready);
      n_fail++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin tick(); n++; end
    n_tests++;
    if (busy !== 1'b0) begin
      $display("FAIL wait_idle_timeout: busy=%b, required 0", busy);
      n_fail++;
    end
  endtask

  task automatic check_sb_empty(input string name);
    n_tests++;
    if (sb_q.size() != 0) begin
      $display("FAIL %s_sb_empty: %0d writes outstanding, required 0", name, sb_q.size());
      n_fail++;
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_word = '0;
    base_addr = '0; word_count = '0;
    repeat (3) tick();
    n_tests++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, busy, done, wrap_err} !== 23'h0) begin
      $display("FAIL reset_outputs: got ready=%b we=%b addr=%h data=%h busy=%b done=%b wrap=%b, required all 0",
               in_ready, mem_we, mem_addr, mem_wdata, busy, done, wrap_err);
      n_fail++;
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [7:0] exp_b [4];
    int d0;
    exp_b = '{8'h8C, 8'h01, 8'h00, 8'h04};
    d0 = done_cnt;
    push_word(10'h000, 32'h8C010004);
    pulse_start(10'h000, 9'd1);
    n_tests++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL single_accept: ready=%b busy=%b, required 1 1", in_ready, busy);
      n_fail++;
    end
    in_word = 32'h8C010004; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (mem_we !== 1'b1 || mem_addr !== 10'(k) || mem_wdata !== exp_b[k]) begin
        $display("FAIL single_byte%0d: we=%b addr=%h data=%h, required 1 %h %h",
                 k, mem_we, mem_addr, mem_wdata, 10'(k), exp_b[k]);
        n_fail++;
      end
      tick();
    end
    n_tests++;
    if (done !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL single_done_pulse: done=%b we=%b busy=%b, required 1 0 1", done, mem_we, busy);
      n_fail++;
    end
    tick();
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || done_cnt - d0 != 1) begin
      $display("FAIL single_done_end: done=%b busy=%b pulses=%0d, required 0 0 1", done, busy, done_cnt - d0);
      n_fail++;
    end
    check_sb_empty("single");
  endtask

  task automatic test_unaligned();
    int d0;
    d0 = done_cnt;
    push_word(10'h100, 32'h11223344);
    push_word(10'h104, 32'hAABBCCDD);
    pulse_start(10'h102, 9'd2);
    send_word(32'h11223344);
    send_word(32'hAABBCCDD);
    wait_idle();
    tick();
    n_tests++;
    if (wrap_err !== 1'b0 || done_cnt - d0 != 1) begin
      $display("FAIL unaligned_status: wrap=%b pulses=%0d, required 0 1", wrap_err, done_cnt - d0);
      n_fail++;
    end
    check_sb_empty("unaligned");
  endtask

  task automatic test_wrap();
    int n;
    push_word(10'h3FC, 32'hDEADBEEF);
    push_word(10'h000, 32'h01234567);
    pulse_start(10'h3FC, 9'd2);
    send_word(32'hDEADBEEF);
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin tick(); n++; end
    n_tests++;
    if (wrap_err !== 1'b1 || in_ready !== 1'b1) begin
      $display("FAIL wrap_after_3ff: wrap=%b ready=%b, required 1 1", wrap_err, in_ready);
      n_fail++;
    end
    send_word(32'h01234567);
    wait_idle();
    repeat (3) tick();
    n_tests++;
    if (wrap_err !== 1'b1) begin
      $display("FAIL wrap_sticky: wrap=%b, required 1", wrap_err);
      n_fail++;
    end
    check_sb_empty("wrap");
  endtask

  task automatic test_zero();
    int d0;
    d0 = done_cnt;
    pulse_start(10'h020, 9'd0);
    n_tests++;
    if (done !== 1'b1 || in_ready !== 1'b0 || mem_we !== 1'b0 || wrap_err !== 1'b0) begin
      $display("FAIL zero_done: done=%b ready=%b we=%b wrap=%b, required 1 0 0 0",
               done, in_ready, mem_we, wrap_err);
      n_fail++;
    end
    tick();
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || done_cnt - d0 != 1) begin
      $display("FAIL zero_end: done=%b busy=%b pulses=%0d, required 0 0 1", done, busy, done_cnt - d0);
      n_fail++;
    end
    check_sb_empty("zero");
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = done_cnt;
    sb_q.push_back({10'h040, 8'hCA});
    sb_q.push_back({10'h041, 8'hFE});
    sb_q.push_back({10'h042, 8'hBA});
    pulse_start(10'h040, 9'd2);
    send_word(32'hCAFEBABE);
    tick(); tick();
    n_tests++;
    if (mem_we !== 1'b1 || mem_addr !== 10'h042) begin
      $display("FAIL rstmid_idx2: we=%b addr=%h, required 1 042", mem_we, mem_addr);
      n_fail++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL rstmid_after: we=%b busy=%b done=%b, required 0 0 0", mem_we, busy, done);
      n_fail++;
    end
    in_valid = 1'b1;
    repeat (8) tick();
    in_valid = 1'b0;
    n_tests++;
    if (done_cnt != d0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      $display("FAIL rstmid_quiet: pulses=%0d busy=%b ready=%b, required 0 0 0", done_cnt - d0, busy, in_ready);
      n_fail++;
    end
    check_sb_empty("rstmid");
    // rst and start together: reset wins.
    rst = 1'b1;
    pulse_start(10'h000, 9'd4);
    rst = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin
      $display("FAIL rst_over_start: busy=%b, required 0", busy);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_random_valid();
    logic [31:0] words [3];
    int d0, w0, k, n;
    logic acc;
    d0 = done_cnt; w0 = wr_cnt; k = 0;
    for (int i = 0; i < 3; i++) begin
      words[i] = $urandom;
      push_word(10'h200 + 10'(4*i), words[i]);
    end
    pulse_start(10'h201, 9'd3);
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      in_valid = 1'($urandom_range(0, 1));
      in_word  = (k < 3) ? words[k] : 32'hFFFFFFFF;
      start    = (n == 4 || n == 17) ? 1'b1 : 1'b0;
      acc      = in_valid & in_ready;
      tick();
      if (acc) k++;
      n++;
    end
    start = 1'b0; in_valid = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (wr_cnt - w0 != 12 || done_cnt - d0 != 1 || k != 3 || busy !== 1'b0) begin
      $display("FAIL random_load: writes=%0d pulses=%0d accepted=%0d busy=%b, required 12 1 3 0",
               wr_cnt - w0, done_cnt - d0, k, busy);
      n_fail++;
    end
    check_sb_empty("random");
  endtask

  task automatic test_clamp();
    int w0, d0;
    w0 = wr_cnt; d0 = done_cnt;
    for (int i = 0; i < 256; i++) push_word(10'(4*i), 32'(i) ^ 32'h5A5A0000);
    pulse_start(10'h000, 9'd300);
    for (int i = 0; i < 256; i++) send_word(32'(i) ^ 32'h5A5A0000);
    wait_idle();
    tick();
    n_tests++;
    if (wr_cnt - w0 != 1024 || done_cnt - d0 != 1) begin
      $display("FAIL clamp_256: writes=%0d pulses=%0d, required 1024 1", wr_cnt - w0, done_cnt - d0);
      n_fail++;
    end
    check_sb_empty("clamp");
  endtask

  initial begin
    test_reset();
    test_single();
    test_unaligned();
    test_wrap();
    test_zero();
    test_reset_mid();
    test_random_valid();
    test_clamp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
